// File: rtl/mem_access_unit_if.sv
// Bus bundle between the control FSM, the memory port and mem_access_unit.
//   req_*  : request from the control FSM (valid/ready handshake)
//   mem_*  : memory port (held strobes, completion pulse mem_resp)
//   rsp_*  : one-cycle completion report back to the control FSM
// Modports: slave = the access unit itself, master = its environment.
interface mem_access_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [NB-1:0]     mem_byte_enable;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_resp;

    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [NB-1:0]     rsp_mask;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready,
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_mask
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready,
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_mask
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer between the control FSM and the memory port.
// Takes one request at a time, drives an aligned address, lane enables and
// lane-shifted store data, waits for mem_resp (optionally bounded by a
// timeout) and reports extended load data or an error for one cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_access_unit_if.slave (req_*, mem_*, rsp_* groups)
module mem_access_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OB = $clog2(NB);
    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen during the last allowed ACCESS cycle.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e state_q, state_d;

    logic              write_q;
    logic [2:0]        funct3_q;
    logic [OB-1:0]     off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              to_q, to_d;
    logic [NB-1:0]     mask_q, mask_d;

    logic              capture;

    // Request decode, evaluated on the live request fields.
    logic [OB-1:0]   req_off;
    logic [2:0]      off3;
    logic            req_illegal;
    logic            req_misaligned;
    logic [NB-1:0]   size_mask;
    logic [NB-1:0]   req_be;
    logic [XLEN-1:0] req_wd;

    assign req_off = bus.req_addr[OB-1:0];
    assign off3    = 3'(req_off);

    always_comb begin
        req_illegal = (bus.req_funct3 == 3'b111) || (bus.req_write && bus.req_funct3[2]);
        if (XLEN == 32 && (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110)) begin
            req_illegal = 1'b1;
        end
        unique case (bus.req_funct3[1:0])
            2'b00: begin req_misaligned = 1'b0;       size_mask = NB'(1);    end
            2'b01: begin req_misaligned = off3[0];    size_mask = NB'(2'b11); end
            2'b10: begin req_misaligned = |off3[1:0]; size_mask = NB'(4'hF);  end
            default: begin req_misaligned = |off3;    size_mask = '1;         end
        endcase
    end

    assign req_be = size_mask << req_off;
    assign req_wd = bus.req_wdata << {req_off, 3'b000};

    // Load data: move the addressed lane down, then extend by access width.
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
            3'b100:  load_ext = XLEN'(shifted[7:0]);
            3'b101:  load_ext = XLEN'(shifted[15:0]);
            3'b110:  load_ext = XLEN'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        mask_d  = mask_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    capture = 1'b1;
                    rdata_d = '0;
                    mask_d  = '0;
                    to_d    = 1'b0;
                    if (req_illegal || req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + CW'(1);
                // mem_resp takes priority over a coincident timeout.
                if (bus.mem_resp) begin
                    rdata_d = write_q ? '0 : load_ext;
                    mask_d  = be_q;
                    to_d    = 1'b0;
                    state_d = StResp;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
            mask_q  <= mask_d;
            if (capture) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                off_q    <= req_off;
                addr_q   <= {bus.req_addr[ADDR_W-1:OB], OB'(0)};
                be_q     <= req_be;
                wdata_q  <= req_wd;
            end
        end
    end

    logic in_access;
    assign in_access = (state_q == StAccess);

    // Strobes decode from state so an async reset drops them at once.
    assign bus.req_ready       = (state_q == StIdle);
    assign bus.mem_read        = in_access && !write_q;
    assign bus.mem_write       = in_access && write_q;
    assign bus.mem_address     = in_access ? addr_q  : '0;
    assign bus.mem_byte_enable = in_access ? be_q    : '0;
    assign bus.mem_wdata       = in_access ? wdata_q : '0;

    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = to_q;
    assign bus.rsp_mask    = mask_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised multicycle load/store sequencer that sits between the datapath control FSM and the memory port.
- Accepts one load or store request at a time. Generates the word-aligned address, byte enables and lane-shifted write data, and waits on mem_resp.
- Returns sign- or zero-extended load data, or an error.
- Adds sub-word access, XLEN=64 support, misalignment/illegal-funct3 detection and an optional memory timeout. The current controller has none of these.

Parameters:
XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 bytes, OB = log2(NB) offset bits
ADDR_W, 32, address width
TIMEOUT_CYCLES, 0, maximum cycles spent waiting for mem_resp; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request strobe from the control FSM; sampled only when req_ready=1
req_ready  out  1  unit is idle and can accept a request
req_write  in  1  1=store, 0=load
req_funct3  in  3  RV funct3 (lb/sb 000, lh/sh 001, lw/sw 010, ld/sd 011, lbu 100, lhu 101, lwu 110)
req_addr  in  ADDR_W  byte address (rs1 + offset)
req_wdata  in  XLEN  store data (rs2), right-justified
mem_address  out  ADDR_W  req_addr with the low OB bits forced to 0
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_byte_enable  out  NB  lane enables
mem_wdata  out  XLEN  lane-shifted store data
mem_rdata  in  XLEN  read data, valid when mem_resp=1
mem_resp  in  1  memory completion pulse
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access or illegal funct3
rsp_timeout  out  1  memory did not respond within TIMEOUT_CYCLES
rsp_mask  out  NB  rmask (loads) or wmask (stores) of the completed access, for the RVFI monitor

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=1; all other outputs 0; timeout counter cleared.
- A reset asserted during ACCESS drops mem_read/mem_write immediately. No response is issued for the aborted request.
- States and transitions:
  - IDLE: req_ready=1.
  - IDLE -> ACCESS when req_valid and the request is legal.
  - IDLE -> RESP with rsp_err=1 when req_valid and the request is illegal or misaligned.
  - ACCESS: mem_read or mem_write held high, and mem_address/mem_byte_enable/mem_wdata held stable, until exit.
  - ACCESS -> RESP on mem_resp.
  - ACCESS -> RESP with rsp_timeout=1 when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no mem_resp.
  - If mem_resp and the timeout occur in the same cycle, mem_resp wins and rsp_timeout=0.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
  - req_ready=0 in ACCESS and RESP; req_valid is ignored there.
- Latency: request accepted at cycle 0; ACCESS from cycle 1; with mem_resp at cycle k, rsp_valid occurs at k+1. Best case is rsp_valid at cycle 2. An error gives rsp_valid at cycle 1 with no memory strobe.
- Legality:
  - Illegal funct3 when XLEN=32: 011, 110, 111.
  - Illegal funct3 when XLEN=64: 111.
  - Illegal for stores: any funct3 > 011.
  - Misaligned: half with off[0]!=0; word with off[1:0]!=0; double with off[2:0]!=0. Here off = req_addr[OB-1:0].
- Byte enables (size mask shifted left by off):
  - byte: 1<<off
  - half: 2'b11<<off
  - word: 4'hF<<off
  - double: all ones
- Store data: mem_wdata = req_wdata << (8*off). Bits shifted out are dropped.
- Load data: x = mem_rdata >> (8*off), then extended by width:
  - lb/lh/lw: sign-extended from bit 7/15/31.
  - lbu/lhu/lwu: zero-extended.
  - lw, XLEN=32: passed through unchanged.
- All request fields are registered at acceptance. Later changes to req_* have no effect on the request in flight.
- Timeout counter: cleared on entry to ACCESS; increments each cycle spent in ACCESS; width clog2(TIMEOUT_CYCLES+1).
- rsp_rdata, rsp_err, rsp_timeout and rsp_mask are registered and valid only while rsp_valid=1.

Test Plan:
- XLEN=32, load lb, addr 0x103, mem_rdata 0x80FF_1234 at resp -> mem_address 0x100, mem_byte_enable 4'b1000, rsp_rdata 0xFFFF_FF80, rsp_mask 4'b1000.
- Store sh, addr 0x202, wdata 0x0000_BEEF -> mem_write=1, mem_byte_enable 4'b1100, mem_wdata 0xBEEF_0000; rsp_valid one cycle after mem_resp, rsp_rdata=0.
- Load lw, addr 0x006 -> no mem_read asserted; rsp_valid on cycle 1 with rsp_err=1. funct3 111 -> same response.
- TIMEOUT_CYCLES=4, load with mem_resp held low -> mem_read high for 4 cycles, then rsp_valid with rsp_timeout=1. mem_resp coinciding with the 4th cycle -> rsp_timeout=0 and data returned.
- XLEN=64, lwu at offset 4, mem_rdata 0xDEAD_BEEF_0000_0000 -> byte_enable 8'hF0, rsp_rdata 0x0000_0000_DEAD_BEEF. sd at offset 0 -> byte_enable 8'hFF.
- Assert rst while in ACCESS with mem_read=1 -> mem_read drops in the same cycle, req_ready=1, no rsp_valid. A new request after reset completes normally.
